// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: req/ack instruction fetch,
// decoder hand-off, conditional jump redirect, link and jump counters.
module pc_sequencer #(
  parameter logic [0:15] P_RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_fetchReq,
  output logic [0:15] o_fetchAddr,
  input  logic        i_fetchAck,
  input  logic [0:15] i_fetchData,
  output logic [0:15] o_instr,
  output logic        o_instrValid,
  input  logic        i_instrTaken,
  input  logic        i_isJump,
  input  logic        i_isHalt,
  input  logic        i_cond,
  input  logic [0:15] i_jTarget,
  output logic [0:15] o_pc,
  output logic [0:15] o_link,
  output logic        o_jumpTaken,
  output logic [0:15] o_jumpCount,
  output logic        o_halted
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [0:15] r_pc;
  logic [0:15] r_instr;
  logic [0:15] r_instrPc;
  logic [0:15] r_link;
  logic [0:15] r_jumpCount;
  logic        r_fetchReq;
  logic        r_instrValid;
  logic        r_halted;
  logic        r_jumpTaken;

  logic w_ack;
  logic w_take;
  logic w_jump;

  assign w_ack  = (r_state == S_FETCH) && i_fetchAck;
  assign w_take = (r_state == S_ISSUE) && i_instrTaken;
  // Halt wins over a jump retired in the same cycle
  assign w_jump = w_take && !i_isHalt && i_isJump && i_cond;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_BOOT:  w_next = S_FETCH;
      S_FETCH: if (w_ack) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_take) w_next = i_isHalt ? S_HALT : S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_BOOT;
      r_pc         <= P_RESET_PC;
      r_instr      <= '0;
      r_instrPc    <= '0;
      r_link       <= '0;
      r_jumpCount  <= '0;
      r_fetchReq   <= 1'b0;
      r_instrValid <= 1'b0;
      r_halted     <= 1'b0;
      r_jumpTaken  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fetchReq   <= (w_next == S_FETCH);
      r_instrValid <= (w_next == S_ISSUE);
      r_halted     <= (w_next == S_HALT);
      r_jumpTaken  <= w_jump;
      if (w_ack) begin
        r_instr   <= i_fetchData;
        r_instrPc <= r_pc;
        r_pc      <= r_pc + 16'd1;
      end
      // Not-taken jumps keep the already incremented PC
      if (w_jump) begin
        r_pc        <= i_jTarget;
        r_link      <= r_instrPc + 16'd1;
        r_jumpCount <= r_jumpCount + 16'd1;
      end
    end
  end

  assign o_fetchReq   = r_fetchReq;
  assign o_fetchAddr  = r_pc & {16{r_fetchReq}};
  assign o_instr      = r_instr;
  assign o_instrValid = r_instrValid;
  assign o_pc         = r_instrPc;
  assign o_link       = r_link;
  assign o_jumpTaken  = r_jumpTaken;
  assign o_jumpCount  = r_jumpCount;
  assign o_halted     = r_halted;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the 16-bit CPU. It is the consumer of the jump-condition bit produced by the condition evaluator:
- fetches instruction words over a req/ack memory handshake;
- presents each word to the decoder;
- on a jump instruction, samples the evaluated condition and redirects the PC to the jump target when it is set.

It also keeps a link register and a taken-jump counter for the debug port.

## Interface
- P_RESET_PC, 16'h0000, PC value loaded on reset
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- o_fetchReq  output  1  fetch request to instruction memory
- o_fetchAddr  output  [0:15]  fetch address (current PC), valid while o_fetchReq=1
- i_fetchAck  input  1  memory accepts request; i_fetchData valid in the same cycle
- i_fetchData  input  [0:15]  fetched instruction word
- o_instr  output  [0:15]  instruction word presented to decoder
- o_instrValid  output  1  o_instr valid
- i_instrTaken  input  1  decoder consumes o_instr this cycle
- i_isJump  input  1  presented instruction is a (conditional) jump; sampled only with i_instrTaken
- i_isHalt  input  1  presented instruction is halt; sampled only with i_instrTaken
- i_cond  input  1  evaluated jump condition from condition evaluator (1 = jump)
- i_jTarget  input  [0:15]  jump destination
- o_pc  output  [0:15]  address of the instruction held in o_instr
- o_link  output  [0:15]  return address (jump PC + 1) of the last taken jump
- o_jumpTaken  output  1  one-cycle pulse: taken jump retired
- o_jumpCount  output  [0:15]  number of taken jumps, wraps modulo 2^16
- o_halted  output  1  sequencer in halt state

## Operation
- States: S_BOOT, S_FETCH, S_ISSUE, S_HALT.
- Reset (i_rst=1 at an edge, any state): state←S_BOOT, PC←P_RESET_PC, o_fetchReq←0, o_instrValid←0, o_instr←0, o_pc←0, o_link←0, o_jumpTaken←0, o_jumpCount←0, o_halted←0. Reset overrides every other input in that cycle.
- S_BOOT: unconditionally → S_FETCH next cycle.
- S_FETCH:
  - o_fetchReq=1, o_fetchAddr=PC; held stable until ack.
  - On i_fetchAck: o_instr←i_fetchData, o_pc←PC, PC←PC+1 (mod 2^16; 16'hFFFF wraps to 16'h0000), → S_ISSUE.
- S_ISSUE: o_instrValid=1, o_instr and o_pc held stable until i_instrTaken. On i_instrTaken:
  - i_isHalt=1 → S_HALT (takes priority over i_isJump).
  - i_isJump=1, i_cond=1:
    - PC←i_jTarget, o_link←o_pc+1 (wrapping);
    - o_jumpCount←o_jumpCount+1, o_jumpTaken pulses next cycle;
    - → S_FETCH.
  - i_isJump=1, i_cond=0: PC unchanged (already o_pc+1), → S_FETCH.
  - otherwise → S_FETCH.
- S_HALT: o_halted=1, no requests, o_instrValid=0; exits only via reset.
- i_fetchAck outside S_FETCH is ignored.
- i_instrTaken outside S_ISSUE is ignored.
- i_jTarget equal to o_pc (self-loop) is legal.

## Timing
- o_fetchReq, o_instrValid, o_halted are registered state decodes; no combinational path from any input to any output.
- The first o_fetchReq is high in the 2nd cycle after reset deasserts (the S_BOOT cycle comes first).
- Ack in cycle N → o_instrValid=1 and new o_instr in cycle N+1.
- Ack may arrive in the same cycle the request first asserts; wait states are unbounded.
- Taken in cycle M → o_fetchReq=1 with redirected or sequential address in cycle M+1.
- o_jumpTaken is high only in cycle M+1.
- Zero-wait memory and decoder give a throughput of 1 instruction per 2 cycles.
- i_cond, i_isJump, i_jTarget need only be valid in the cycle i_instrTaken=1.

## Test plan
- Reset with P_RESET_PC=16'h0010:
  - after reset, cycle 1 has o_fetchReq=0;
  - cycle 2 has o_fetchReq=1, o_fetchAddr=16'h0010;
  - all other outputs are 0.
- Sequential run, zero-wait ack, words 16'hA000..16'hA003: o_pc steps 0x0010→0x0013, with o_instrValid high every other cycle.
- Taken jump: instruction at 0x0012 taken with i_isJump=1, i_cond=1, i_jTarget=16'h0100:
  - next o_fetchAddr=16'h0100;
  - o_link=16'h0013;
  - o_jumpCount=1;
  - o_jumpTaken pulses one cycle.
- Not-taken jump: same stimulus with i_cond=0 → next o_fetchAddr=16'h0013; o_jumpCount and o_link unchanged.
- Boundaries:
  - PC at 16'hFFFF, non-jump instruction → next fetch at 16'h0000;
  - 3-cycle ack delay → o_fetchAddr held stable for all 3 cycles;
  - a stray ack during S_ISSUE is ignored.
- Halt and mid-operation reset:
  - i_isHalt=1 together with i_isJump=1, i_cond=1 → S_HALT, o_halted=1, no further requests, o_jumpCount unchanged;
  - i_rst asserted while S_FETCH is waiting for ack (and, separately, with i_fetchAck=1 in the same cycle) → full reset values, restart at P_RESET_PC.
